// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: CPU-side requests and controls in, redirect and status out.
interface interrupt_controller_if;
    logic [2:0]  irqRequest;
    logic [2:0]  irqMask;
    logic        cpuAdvance;
    logic [31:0] pcNext;
    logic        eret;
    logic        pcOverride;
    logic [31:0] pcTarget;
    logic        intTaken;
    logic [2:0]  pending;
    logic [2:0]  inService;
    logic [1:0]  depth;

    // Controller side.
    modport slave (
        input  irqRequest, irqMask, cpuAdvance, pcNext, eret,
        output pcOverride, pcTarget, intTaken, pending, inService, depth
    );

    // CPU / environment side.
    modport master (
        output irqRequest, irqMask, cpuAdvance, pcNext, eret,
        input  pcOverride, pcTarget, intTaken, pending, inService, depth
    );
endinterface

// File: rtl/interrupt_controller.sv
// Three-source nested interrupt controller with edge-latched requests,
// strict-priority preemption and a 3-deep return-address (EPC) stack.
module interrupt_controller #(
    parameter logic [31:0] VEC0 = 32'h0000_0100,
    parameter logic [31:0] VEC1 = 32'h0000_0200,
    parameter logic [31:0] VEC2 = 32'h0000_0300
) (
    input logic                   clk,
    input logic                   rst_n,
    interrupt_controller_if.slave bus
);

    logic [2:0]  irq_q;
    logic [2:0]  pending_q;
    logic [2:0]  in_service_q;
    logic [1:0]  depth_q;
    logic [31:0] epc [3];

    logic [2:0]  rise;
    logic [2:0]  armed;
    logic        cand_valid;
    logic [1:0]  cand_idx;
    logic [1:0]  svc_level;     // 0 = idle, otherwise highest in-service index + 1
    logic        eligible;
    logic        do_take;
    logic        do_return;
    logic [31:0] vector;
    logic [2:0]  take_mask;
    logic [2:0]  top_mask;

    assign rise  = bus.irqRequest & ~irq_q;
    assign armed = pending_q & bus.irqMask;

    // Pick the highest armed source and the current service level.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cand_valid = 1'b0;
        cand_idx   = 2'd0;
        svc_level  = 2'd0;
        if (armed[2]) begin
            cand_valid = 1'b1;
            cand_idx   = 2'd2;
        end else if (armed[1]) begin
            cand_valid = 1'b1;
            cand_idx   = 2'd1;
        end else if (armed[0]) begin
            cand_valid = 1'b1;
            cand_idx   = 2'd0;
        end
        if (in_service_q[2])      svc_level = 2'd3;
        else if (in_service_q[1]) svc_level = 2'd2;
        else if (in_service_q[0]) svc_level = 2'd1;
    end

    // A candidate preempts only when strictly above everything in service.
    assign eligible  = cand_valid && ((cand_idx + 2'd1) > svc_level);
    assign do_return = bus.cpuAdvance && bus.eret && (depth_q != 2'd0);
    assign do_take   = bus.cpuAdvance && !bus.eret && eligible;
    assign take_mask = 3'b001 << cand_idx;
    assign top_mask  = (svc_level == 2'd0) ? 3'b000 : (3'b001 << (svc_level - 2'd1));

    // Map the winning source to its handler address.
    always_comb begin
        case (cand_idx)
            2'd2:    vector = VEC2;
            2'd1:    vector = VEC1;
            default: vector = VEC0;
        endcase
    end

    // Same-cycle PC redirect; a return beats a take, idle drives zeros.
    always_comb begin
        bus.pcOverride = 1'b0;
        bus.pcTarget   = 32'h0;
        bus.intTaken   = 1'b0;
        if (do_return) begin
            bus.pcOverride = 1'b1;
            bus.pcTarget   = epc[depth_q - 2'd1];
        end else if (do_take) begin
            bus.pcOverride = 1'b1;
            bus.pcTarget   = vector;
            bus.intTaken   = 1'b1;
        end
    end

    // Edge capture, pending/in-service bookkeeping and EPC stack push/pop.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (!rst_n) begin
            irq_q        <= 3'b000;
            pending_q    <= 3'b000;
            in_service_q <= 3'b000;
            depth_q      <= 2'd0;
            // NOTE: the EPC stack is small and reset explicitly so a stray pop can never expose stale addresses.
            for (int i = 0; i < 3; i++) epc[i] <= 32'h0;
        end else begin
            irq_q     <= bus.irqRequest;
            // A fresh rising edge re-arms a source even as it is being taken.
            pending_q <= (pending_q & ~(do_take ? take_mask : 3'b000)) | rise;
            if (do_take) begin
                in_service_q <= in_service_q | take_mask;
                if (depth_q != 2'd3) begin
                    epc[depth_q] <= bus.pcNext;
                    depth_q      <= depth_q + 2'd1;
                end
            end else if (do_return) begin
                in_service_q <= in_service_q & ~top_mask;
                depth_q      <= depth_q - 2'd1;
            end
        end
    end

    assign bus.pending   = pending_q;
    assign bus.inService = in_service_q;
    assign bus.depth     = depth_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: each task queues the redirects it expects, a negedge
// monitor pops and compares them, and tasks check latched state inline.
module tb_interrupt_controller;

    logic clk;
    logic rst_n;
    logic mon_en;
    int   checks;
    int   errors;

    typedef struct {
        logic [31:0] target;
        logic        taken;
    } exp_t;

    exp_t sb[$];

    interrupt_controller_if bus ();

    interrupt_controller #(
        .VEC0(32'h0000_0100),
        .VEC1(32'h0000_0200),
        .VEC2(32'h0000_0300)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare every cycle's redirect outputs against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.pcOverride === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_redirect: pcTarget=%h intTaken=%b, required no redirect",
                             bus.pcTarget, bus.intTaken);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.pcTarget !== e.target || bus.intTaken !== e.taken) begin
                        errors++;
                        $display("FAIL redirect: pcTarget=%h intTaken=%b, required pcTarget=%h intTaken=%b",
                                 bus.pcTarget, bus.intTaken, e.target, e.taken);
                    end
                end
            end else if (bus.pcOverride !== 1'b0 || bus.pcTarget !== 32'h0 || bus.intTaken !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: pcOverride=%b pcTarget=%h intTaken=%b, required 0/0/0",
                         bus.pcOverride, bus.pcTarget, bus.intTaken);
            end
        end
    end

    // Apply one cycle of inputs and return #1 after the following rising edge.
    task automatic drive(input logic [2:0] req, input logic [2:0] mask, input logic adv,
                         input logic er, input logic [31:0] pc);
        bus.irqRequest = req;
        bus.irqMask    = mask;
        bus.cpuAdvance = adv;
        bus.eret       = er;
        bus.pcNext     = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_redirect(input logic [31:0] target, input logic taken);
        exp_t e;
        e.target = target;
        e.taken  = taken;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: pending=%b inService=%b depth=%0d, required 0/0/0",
                     bus.pending, bus.inService, bus.depth);
        end
        checks++;
        if (bus.pcOverride !== 1'b0 || bus.pcTarget !== 32'h0 || bus.intTaken !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pcOverride=%b pcTarget=%h intTaken=%b, required 0/0/0",
                     bus.pcOverride, bus.pcTarget, bus.intTaken);
        end
    endtask

    task automatic test_single();
        drive(3'b001, 3'b111, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pending !== 3'b001) begin
            errors++;
            $display("FAIL single_pending: pending=%b, required 001", bus.pending);
        end
        expect_redirect(32'h100, 1'b1);
        drive(3'b001, 3'b111, 1'b1, 1'b0, 32'h40);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== {3'b000, 3'b001, 2'd1}) begin
            errors++;
            $display("FAIL single_state: pending=%b inService=%b depth=%0d, required 000/001/1",
                     bus.pending, bus.inService, bus.depth);
        end
    endtask

    task automatic test_nesting();
        drive(3'b101, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h300, 1'b1);
        drive(3'b101, 3'b111, 1'b1, 1'b0, 32'h108);
        checks++;
        if ({bus.inService, bus.depth} !== {3'b101, 2'd2}) begin
            errors++;
            $display("FAIL nest_enter: inService=%b depth=%0d, required 101/2", bus.inService, bus.depth);
        end
        expect_redirect(32'h108, 1'b0);
        drive(3'b101, 3'b111, 1'b1, 1'b1, 32'h304);
        checks++;
        if ({bus.inService, bus.depth} !== {3'b001, 2'd1}) begin
            errors++;
            $display("FAIL nest_ret1: inService=%b depth=%0d, required 001/1", bus.inService, bus.depth);
        end
        expect_redirect(32'h40, 1'b0);
        drive(3'b101, 3'b111, 1'b1, 1'b1, 32'h10c);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== 8'h00) begin
            errors++;
            $display("FAIL nest_ret2: pending=%b inService=%b depth=%0d, required 000/000/0",
                     bus.pending, bus.inService, bus.depth);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL nest_missing: %0d redirects outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_priority_block();
        drive(3'b000, 3'b111, 1'b0, 1'b0, 32'h0);
        drive(3'b100, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h300, 1'b1);
        drive(3'b100, 3'b111, 1'b1, 1'b0, 32'h50);
        drive(3'b110, 3'b111, 1'b1, 1'b0, 32'h54);
        drive(3'b110, 3'b111, 1'b1, 1'b0, 32'h58);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== {3'b010, 3'b100, 2'd1}) begin
            errors++;
            $display("FAIL prio_block: pending=%b inService=%b depth=%0d, required 010/100/1",
                     bus.pending, bus.inService, bus.depth);
        end
        expect_redirect(32'h50, 1'b0);
        drive(3'b110, 3'b111, 1'b1, 1'b1, 32'h5c);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== {3'b010, 3'b000, 2'd0}) begin
            errors++;
            $display("FAIL prio_ret: pending=%b inService=%b depth=%0d, required 010/000/0",
                     bus.pending, bus.inService, bus.depth);
        end
        expect_redirect(32'h200, 1'b1);
        drive(3'b110, 3'b111, 1'b1, 1'b0, 32'h60);
        expect_redirect(32'h60, 1'b0);
        drive(3'b110, 3'b111, 1'b1, 1'b1, 32'h204);
        checks++;
        if (sb.size() !== 0 || bus.depth !== 2'd0) begin
            errors++;
            $display("FAIL prio_end: outstanding=%0d depth=%0d, required 0/0", sb.size(), bus.depth);
        end
    endtask

    task automatic test_mask();
        drive(3'b000, 3'b101, 1'b0, 1'b0, 32'h0);
        drive(3'b010, 3'b101, 1'b0, 1'b0, 32'h0);
        drive(3'b010, 3'b101, 1'b1, 1'b0, 32'h64);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== {3'b010, 3'b000, 2'd0}) begin
            errors++;
            $display("FAIL mask_hold: pending=%b inService=%b depth=%0d, required 010/000/0",
                     bus.pending, bus.inService, bus.depth);
        end
        expect_redirect(32'h200, 1'b1);
        drive(3'b010, 3'b111, 1'b1, 1'b0, 32'h70);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== {3'b000, 3'b010, 2'd1}) begin
            errors++;
            $display("FAIL mask_take: pending=%b inService=%b depth=%0d, required 000/010/1",
                     bus.pending, bus.inService, bus.depth);
        end
        expect_redirect(32'h70, 1'b0);
        drive(3'b010, 3'b111, 1'b1, 1'b1, 32'h204);
    endtask

    task automatic test_collision();
        drive(3'b000, 3'b111, 1'b0, 1'b0, 32'h0);
        drive(3'b001, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h100, 1'b1);
        drive(3'b001, 3'b111, 1'b1, 1'b0, 32'h80);
        drive(3'b011, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h80, 1'b0);
        drive(3'b011, 3'b111, 1'b1, 1'b1, 32'h84);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== {3'b010, 3'b000, 2'd0}) begin
            errors++;
            $display("FAIL collide_eret: pending=%b inService=%b depth=%0d, required 010/000/0",
                     bus.pending, bus.inService, bus.depth);
        end
        expect_redirect(32'h200, 1'b1);
        drive(3'b011, 3'b111, 1'b1, 1'b0, 32'h90);
        expect_redirect(32'h90, 1'b0);
        drive(3'b011, 3'b111, 1'b1, 1'b1, 32'h204);
    endtask

    task automatic test_set_wins();
        drive(3'b000, 3'b110, 1'b0, 1'b0, 32'h0);
        drive(3'b001, 3'b110, 1'b0, 1'b0, 32'h0);
        drive(3'b000, 3'b110, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h100, 1'b1);
        drive(3'b001, 3'b111, 1'b1, 1'b0, 32'ha0);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== {3'b001, 3'b001, 2'd1}) begin
            errors++;
            $display("FAIL set_wins: pending=%b inService=%b depth=%0d, required 001/001/1",
                     bus.pending, bus.inService, bus.depth);
        end
        expect_redirect(32'ha0, 1'b0);
        drive(3'b001, 3'b111, 1'b1, 1'b1, 32'h104);
        expect_redirect(32'h100, 1'b1);
        drive(3'b001, 3'b111, 1'b1, 1'b0, 32'hb0);
        expect_redirect(32'hb0, 1'b0);
        drive(3'b001, 3'b111, 1'b1, 1'b1, 32'h104);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ret_pc [3];
        ret_pc = '{32'hc0, 32'hc4, 32'hc8};
        drive(3'b000, 3'b111, 1'b0, 1'b0, 32'h0);
        drive(3'b001, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h100, 1'b1);
        drive(3'b001, 3'b111, 1'b1, 1'b0, ret_pc[0]);
        drive(3'b011, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h200, 1'b1);
        drive(3'b011, 3'b111, 1'b1, 1'b0, ret_pc[1]);
        drive(3'b111, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h300, 1'b1);
        drive(3'b111, 3'b111, 1'b1, 1'b0, ret_pc[2]);
        checks++;
        if ({bus.inService, bus.depth} !== {3'b111, 2'd3}) begin
            errors++;
            $display("FAIL full_depth: inService=%b depth=%0d, required 111/3", bus.inService, bus.depth);
        end
        for (int i = 2; i >= 0; i--) begin
            expect_redirect(ret_pc[i], 1'b0);
            drive(3'b111, 3'b111, 1'b1, 1'b1, 32'h400);
            checks++;
            if (bus.depth !== 2'(i)) begin
                errors++;
                $display("FAIL unwind_depth: depth=%0d, required %0d", bus.depth, i);
            end
        end
        checks++;
        if (bus.inService !== 3'b000 || sb.size() !== 0) begin
            errors++;
            $display("FAIL unwind_end: inService=%b outstanding=%0d, required 000/0",
                     bus.inService, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(3'b000, 3'b111, 1'b0, 1'b0, 32'h0);
        drive(3'b001, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h100, 1'b1);
        drive(3'b001, 3'b111, 1'b1, 1'b0, 32'hd0);
        drive(3'b011, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_redirect(32'h200, 1'b1);
        drive(3'b011, 3'b111, 1'b1, 1'b0, 32'hd4);
        checks++;
        if (bus.depth !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_depth: depth=%0d, required 2", bus.depth);
        end
        rst_n = 1'b0;
        drive(3'b000, 3'b111, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== 8'h00 ||
            bus.pcOverride !== 1'b0 || bus.pcTarget !== 32'h0 || bus.intTaken !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: pending=%b inService=%b depth=%0d pcOverride=%b pcTarget=%h, required all 0",
                     bus.pending, bus.inService, bus.depth, bus.pcOverride, bus.pcTarget);
        end
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'he0);
        checks++;
        if ({bus.pending, bus.inService, bus.depth} !== 8'h00) begin
            errors++;
            $display("FAIL stray_eret: pending=%b inService=%b depth=%0d, required 000/000/0",
                     bus.pending, bus.inService, bus.depth);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        mon_en         = 1'b0;
        rst_n          = 1'b0;
        bus.irqRequest = 3'b000;
        bus.irqMask    = 3'b111;
        bus.cpuAdvance = 1'b0;
        bus.eret       = 1'b0;
        bus.pcNext     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        test_reset();
        test_single();
        test_nesting();
        test_priority_block();
        test_mask();
        test_collision();
        test_set_wins();
        test_back_to_back();
        test_reset_mid();

        drive(3'b000, 3'b111, 1'b0, 1'b0, 32'h0);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d redirects never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter VEC0, default 32'h0000_0100, handler address for source 0.
REQ-002 SHALL have parameter VEC1, default 32'h0000_0200, handler address for source 1.
REQ-003 SHALL have parameter VEC2, default 32'h0000_0300, handler address for source 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port irqRequest  input  3  interrupt request levels, synchronous to clk; bit 2 is highest priority.
REQ-007 SHALL have port irqMask  input  3  per-source enable; 1 = may be taken.
REQ-008 SHALL have port cpuAdvance  input  1  CPU retires an instruction this cycle (instruction boundary).
REQ-009 SHALL have port pcNext  input  32  address the CPU would fetch next if not redirected.
REQ-010 SHALL have port eret  input  1  decoded return-from-interrupt, valid only with cpuAdvance.
REQ-011 SHALL have port pcOverride  output  1  force PC to pcTarget this cycle.
REQ-012 SHALL have port pcTarget  output  32  redirect address (vector or return address).
REQ-013 SHALL have port intTaken  output  1  one-cycle pulse when an interrupt is entered.
REQ-014 SHALL have port pending  output  3  latched pending requests.
REQ-015 SHALL have port inService  output  3  sources currently being serviced.
REQ-016 SHALL have port depth  output  2  number of live EPC stack entries (0..3).

Function
REQ-017 Edge detect: SHALL register irqRequest each cycle; a 0->1 transition of bit i SHALL set pending[i] at that clock edge; levels held high SHALL NOT re-set it.
REQ-018 Take condition (combinational): cpuAdvance=1, eret=0, candidate i exists where i = highest index with pending[i]&irqMask[i], and i > highest set bit of inService (any i when inService=0).
REQ-019 On take: pcOverride=1, pcTarget=VECi, intTaken=1 same cycle; at the clock edge pending[i] cleared, inService[i] set, pcNext pushed onto the EPC stack, depth incremented.
REQ-020 On eret with cpuAdvance=1 and depth>0: pcOverride=1, pcTarget=top of stack same cycle; at the edge stack popped, depth decremented, highest set bit of inService cleared.
REQ-021 eret with depth=0 SHALL be ignored: pcOverride=0, no state change.
REQ-022 eret and a take-eligible request in the same cycle: eret SHALL win; the request stays pending and is re-evaluated next cycle against the reduced inService.
REQ-023 Rising edge on bit i in the same cycle bit i is taken: set SHALL win (pending[i]=1 after the edge).
REQ-024 Masked pending bits SHALL remain latched and be taken once unmasked.
REQ-025 EPC stack: 3 entries x 32 bits, LIFO; strict-priority nesting bounds depth to 3, so overflow SHALL be unreachable; a push at depth=3 SHALL be suppressed (defensive).
REQ-026 When cpuAdvance=0, pcOverride and intTaken SHALL be 0 and pcTarget SHALL be don't-care-free (driven 0).
REQ-027 Latency: request edge at edge N -> earliest pcOverride during cycle N+1.

Reset
REQ-028 While rst_n=0 at a clock edge: pending=0, inService=0, depth=0, stack entries=0, edge register=0.
REQ-029 Outputs after reset: pcOverride=0, pcTarget=0, intTaken=0; reset mid-service SHALL discard all nesting state.

Verification
REQ-030 Single: irqRequest=3'b001, mask=3'b111, pcNext=0x40, cpuAdvance=1 -> next cycle pcOverride=1, pcTarget=0x100, intTaken=1; after edge inService=001, depth=1.
REQ-031 Nesting: in service 0, edge on bit 2 with pcNext=0x108 -> pcTarget=0x300, depth=2; eret -> pcTarget=0x108, inService=001; eret -> pcTarget=0x44-style saved value 0x40, depth=0.
REQ-032 Priority block: in service 2, edge on bit 1 -> no take, pending=010; after eret, next advancing cycle -> pcTarget=0x200.
REQ-033 Mask: edge on bit 1 with mask=3'b101 -> pending=010, no take; mask=3'b111 -> take to 0x200.
REQ-034 Collision: eret and eligible pending same cycle -> pcTarget=return address, intTaken=0; following cycle take.
REQ-035 Reset mid-service at depth=2 -> all outputs and pending/inService/depth zero; stray eret afterwards ignored.
